// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and flag bit positions for alu_seq
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_EQ  = 4'd5,
    OP_LTU = 4'd6,
    OP_NOP = 4'd7,
    OP_LTS = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_MUL = 4'd11
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_I = 4;
  localparam int NUM_FLAGS = 5;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between an ALU client and alu_seq
interface alu_seq_if #(parameter int WIDTH = 8) ();
  import alu_pkg::*;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic [3:0] opcode;
  logic [NUM_FLAGS-1:0] flags;
  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );
  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle, done after WIDTH partials
module alu_seq_mul #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic busy_q, busy_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  assign done = busy_q && cnt_q == CW'(WIDTH);
  assign step = busy_q && !done;
  assign product = acc_q;
  always_comb begin
    busy_d = start ? 1'b1 : step;
    cnt_d = start ? CW'(1) : step ? cnt_q + CW'(1) : cnt_q;
    acc_d = start ? (b[0] ? {{WIDTH{1'b0}}, a} : '0) : step ? acc_q + (mplier_q[0] ? mcand_q : '0) : acc_q;
    mcand_d = start ? {{(WIDTH-1){1'b0}}, a, 1'b0} : step ? mcand_q << 1 : mcand_q;
    mplier_d = start ? b >> 1 : step ? mplier_q >> 1 : mplier_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative multiplier
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 8) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu_res;
  logic [NUM_FLAGS-1:0] flags_q, flags_d, alu_flags, mul_flags;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0] sum, diff, shl, shr;
  logic ready, accept, is_mul, mul_done, c, v, n_en, ill;
  assign ready = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign is_mul = bus.opcode == OP_MUL;
  assign bus.in_ready = ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.result = res_q;
  assign bus.flags = flags_q;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && is_mul),
    .a(bus.A),
    .b(bus.B),
    .done(mul_done),
    .product(product)
  );
  always_comb begin
    sum = {1'b0, bus.A} + {1'b0, bus.B};
    diff = {1'b0, bus.A} - {1'b0, bus.B};
    shl = {1'b0, bus.A} << bus.B[SW-1:0];
    shr = {bus.A, 1'b0} >> bus.B[SW-1:0];
    alu_res = '0;
    c = 1'b0;
    v = 1'b0;
    n_en = 1'b0;
    ill = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        alu_res = sum[MSB:0];
        c = sum[WIDTH];
        v = bus.A[MSB] == bus.B[MSB] && sum[MSB] != bus.A[MSB];
        n_en = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff[MSB:0];
        c = diff[WIDTH];
        v = bus.A[MSB] != bus.B[MSB] && diff[MSB] != bus.A[MSB];
        n_en = 1'b1;
      end
      OP_AND: begin alu_res = bus.A & bus.B; n_en = 1'b1; end
      OP_OR: begin alu_res = bus.A | bus.B; n_en = 1'b1; end
      OP_XOR: begin alu_res = bus.A ^ bus.B; n_en = 1'b1; end
      OP_EQ: alu_res = WIDTH'(bus.A == bus.B);
      OP_LTU: alu_res = WIDTH'(bus.A < bus.B);
      OP_LTS: alu_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SHL: begin alu_res = shl[MSB:0]; c = shl[WIDTH]; n_en = 1'b1; end
      OP_SHR: begin alu_res = shr[WIDTH:1]; c = shr[0]; n_en = 1'b1; end
      OP_NOP, OP_MUL: ;
      default: ill = 1'b1;
    endcase
    alu_flags = '0;
    alu_flags[FLAG_I] = ill;
    alu_flags[FLAG_N] = n_en && alu_res[MSB];
    alu_flags[FLAG_V] = v;
    alu_flags[FLAG_C] = c;
    alu_flags[FLAG_Z] = alu_res == '0;
    mul_flags = '0;
    mul_flags[FLAG_N] = product[MSB];
    mul_flags[FLAG_C] = |product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_Z] = product[MSB:0] == '0;
  end
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    flags_d = flags_q;
    if (accept) state_d = is_mul ? BUSY : DONE;
    else if (state_q == BUSY && mul_done) state_d = DONE;
    else if (state_q == DONE && bus.out_ready) state_d = IDLE;
    if (accept && !is_mul) begin
      res_d = alu_res;
      flags_d = alu_flags;
    end else if (state_q == BUSY && mul_done) begin
      res_d = product[MSB:0];
      flags_d = mul_flags;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed check of alu_seq results, flags, latency, backpressure and reset
module tb_alu_seq;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] fl;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vecs[19];
  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [4:0] ef);
    int w;
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.opcode = op;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), op == 4'd11 ? 9 : 1);
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " flags"}, 32'(bus.flags), 32'(ef));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b00011};
    vecs[1]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b00100};
    vecs[2]  = '{4'd8,  8'h80, 8'h01, 8'h01, 5'b00000};
    vecs[3]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000};
    vecs[4]  = '{4'd3,  8'h80, 8'h01, 8'h81, 5'b01000};
    vecs[5]  = '{4'd4,  8'hAA, 8'hAA, 8'h00, 5'b00001};
    vecs[6]  = '{4'd5,  8'h05, 8'h05, 8'h01, 5'b00000};
    vecs[7]  = '{4'd6,  8'h01, 8'h80, 8'h01, 5'b00000};
    vecs[8]  = '{4'd7,  8'h12, 8'h34, 8'h00, 5'b00001};
    vecs[9]  = '{4'd9,  8'h81, 8'h01, 8'h02, 5'b00010};
    vecs[10] = '{4'd10, 8'h81, 8'h01, 8'h40, 5'b00010};
    vecs[11] = '{4'd9,  8'h55, 8'h00, 8'h55, 5'b00000};
    vecs[12] = '{4'd10, 8'h80, 8'h07, 8'h01, 5'b00000};
    vecs[13] = '{4'd9,  8'h01, 8'h09, 8'h02, 5'b00000};
    vecs[14] = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b01100};
    vecs[15] = '{4'd1,  8'h00, 8'h01, 8'hFF, 5'b01010};
    vecs[16] = '{4'd15, 8'h3C, 8'hA5, 8'h00, 5'b10001};
    vecs[17] = '{4'd11, 8'h0F, 8'h11, 8'hFF, 5'b01000};
    vecs[18] = '{4'd11, 8'h10, 8'h10, 8'h00, 5'b00011};
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.opcode = '0;
    bus.out_ready = 1'b1;
    #22;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    chk("reset result", 32'(bus.result), 0);
    chk("reset flags", 32'(bus.flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    do_op("hold add", 4'd0, 8'h03, 8'h04, 8'h07, 5'b00000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 0);
      chk($sformatf("hold%0d result", i), 32'(bus.result), 32'h07);
      chk($sformatf("hold%0d flags", i), 32'(bus.flags), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = 8'h0F;
    bus.B = 8'hFF;
    bus.opcode = 4'd4;
    #1;
    chk("b2b out_valid", 32'(bus.out_valid), 1);
    chk("b2b in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("b2b out_valid after", 32'(bus.out_valid), 1);
    chk("b2b result", 32'(bus.result), 32'hF0);
    chk("b2b flags", 32'(bus.flags), 32'b01000);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 8'h0F;
    bus.B = 8'h11;
    bus.opcode = 4'd11;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rst busy in_ready", 32'(bus.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst result", 32'(bus.result), 0);
    chk("rst flags", 32'(bus.flags), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst release in_ready", 32'(bus.in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) cnt++;
      @(posedge clk);
      #1;
    end
    chk("rst no stale out_valid", 32'(cnt), 0);
    do_op("post rst add", 4'd0, 8'h01, 8'h02, 8'h03, 5'b00000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port opcode  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  5  {illegal, negative, overflow, carry, zero}, registered with result.

Function
REQ-013 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQ, 6 LTU, 7 NOP, 8 LTS (signed less-than), 9 SHL, 10 SHR (logical), 11 MUL; 12..15 illegal.
REQ-014 SHALL treat a request as accepted on a rising edge where in_valid and in_ready are both 1; A, B and opcode are captured only then.
REQ-015 SHALL use FSM states IDLE, BUSY, DONE; IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on out_ready with no new accept.
REQ-016 SHALL drive in_ready = 1 in IDLE, = out_ready in DONE (back-to-back accept), = 0 in BUSY.
REQ-017 SHALL, in DONE with out_ready=1 and a new accept, move directly to DONE (single-cycle op) or BUSY (MUL).
REQ-018 SHALL have single-cycle op latency of 1: out_valid high in the cycle after the accept edge.
REQ-019 SHALL compute MUL by shift-add, one partial product per cycle, latency WIDTH+1; result = low WIDTH bits of the unsigned product.
REQ-020 SHALL assert out_valid only in DONE and hold result/flags stable while out_valid=1 and out_ready=0.
REQ-021 SHALL set EQ/LTU/LTS result to 1 or 0 zero-extended to WIDTH; NOP and illegal result = 0.
REQ-022 SHALL use shift amount B[log2(WIDTH)-1:0] for SHL/SHR, zero fill; carry = last bit shifted out (0 if amount 0).
REQ-023 SHALL set zero = (result==0) for every op, including NOP and illegal.
REQ-024 SHALL set carry: ADD carry-out; SUB borrow (A<B unsigned); MUL 1 if high product half nonzero; shifts per REQ-022; else 0.
REQ-025 SHALL set overflow for ADD/SUB on two's-complement signed overflow; else 0.
REQ-026 SHALL set negative = result[WIDTH-1] for ADD/SUB/AND/OR/XOR/SHL/SHR/MUL; else 0.
REQ-027 SHALL set illegal = 1 only for opcodes 12..15; the op still completes with latency 1.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, out_valid 0, result 0, flags 0, multiplier registers 0, regardless of clk.
REQ-029 SHALL abandon any in-flight MUL or held result on reset; no output appears after reset release without a new accept.
REQ-030 SHALL drive in_ready = 1 in the first cycle after reset release.

Structure
REQ-031 SHALL place the opcode enumeration, FSM state type and flag bit-index constants in shared package alu_pkg.
REQ-032 SHALL implement the iterative multiplier as sub-module alu_seq_mul (start, done, WIDTH-parameterised).

Verification (WIDTH=8)
REQ-033 SHALL test ADD 8'hFF+8'h01 -> result 8'h00, zero=1, carry=1, overflow=0, out_valid one cycle after accept.
REQ-034 SHALL test SUB 8'h80-8'h01 -> 8'h7F, overflow=1, carry=0, negative=0; LTS 8'h80,8'h01 -> 8'h01.
REQ-035 SHALL test MUL 8'h0F*8'h11 -> 8'hFF, carry=0, out_valid 9 cycles after accept; MUL 8'h10*8'h10 -> 8'h00, zero=1, carry=1.
REQ-036 SHALL test out_ready held 0 for 5 cycles after a result -> result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept.
REQ-037 SHALL test rst_n pulsed low mid-MUL (cycle 4) -> out_valid=0 immediately, in_ready=1 after release, no stale result.
REQ-038 SHALL test opcode 4'hF -> result 8'h00, illegal=1, zero=1.
